count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Receiving-end monitor for the count stream produced by the team's pipelined counters. It samples an N-bit count bus every clock and checks that each value is the previous value plus one, modulo 2^N. It acquires lock after a run of consecutive good increments, flags each break in the sequence, and reports wrap-around and compare-match events. It sits downstream of a counter's `q` output in self-test and clock-health logic.

## Interface
- `N`, 4: count bus width; must match the producing counter.
- `LOCK_LEN`, 4: consecutive good increments needed to lock; range 1..255.
- `ERR_W`, 8: width of the saturating error counter.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: checker enable; low forces IDLE.
- `q` input N: count stream under test.
- `cmp_val` input N: compare value.
- `err_clr` input 1: synchronous clear of `err_cnt`.
- `locked` output 1: registered; high while in LOCKED.
- `err` output 1: one-cycle pulse on a sequence break while LOCKED.
- `wrap` output 1: one-cycle pulse on a good all-ones to zero step while LOCKED.
- `match` output 1: one-cycle pulse when sampled `q == cmp_val`, in any state.
- `err_cnt` output ERR_W: saturating count of `err` pulses.

## Operation
- States: IDLE, ACQ, LOCKED. Internal registers: `prev` (N bits) and `run` (8 bits).
- A step is good when `q == prev + 1`, truncated to N bits. So 2^N−1 followed by 0 is good.
- IDLE:
  - `en=1` → ACQ, with `prev<=q` and `run<=0`.
  - Otherwise stay in IDLE.
- ACQ:
  - Good step: `run<=run+1`. When `run+1 == LOCK_LEN`, go to LOCKED.
  - Bad step, including a repeated value during the producer's pipeline fill: `run<=0`. No `err`.
- LOCKED:
  - Good step: stay.
  - Bad step: assert `err`, increment `err_cnt`, go to ACQ with `run<=0`.
- In ACQ and LOCKED, `prev<=q` on every sampled edge.
- `en=0` in any state → IDLE on the next edge. `locked` drops and no `err` is generated.
- `err_cnt`:
  - Saturates at 2^ERR_W−1.
  - `err_clr` alone → 0.
  - `err_clr` and an error on the same edge → 1.
- Reset values: state IDLE; `prev`, `run`, `locked`, `err`, `wrap`, `match`, `err_cnt` all 0.

## Timing
- All outputs are registered and reflect the `q` sampled at the preceding edge (1-cycle latency).
- Lock latency: if `q` takes values v, v+1, … on edges 0, 1, …, then `locked` is high after edge LOCK_LEN.
- `err`, `wrap`, `match` are single-cycle pulses. They repeat on consecutive cycles if their conditions repeat.
- `reset_n` asserted mid-operation clears everything immediately (asynchronously). The first edge after deassertion behaves as IDLE.

## Configuration
- `COUNT_CHECKER_ERR_CNT_EN` defined: the `err_cnt` register, saturation logic and `err_clr` are implemented.
- Undefined: `err_cnt` is tied to 0, `err_clr` is ignored, and `err`, `locked`, `wrap`, `match` are unchanged.

## Structure
- Shared package `count_chk_pkg` holds:
  - the state enum typedef (IDLE/ACQ/LOCKED);
  - the `RUN_W=8` constant;
  - a helper function computing the N-bit wrapped successor.
- Sub-module `sat_counter` is natural here: ERR_W-bit, with increment, synchronous clear and saturation. It is instantiated only under `COUNT_CHECKER_ERR_CNT_EN`.

## Test plan
All scenarios use N=4, LOCK_LEN=4, ERR_W=8.
- Lock acquire: `en=1`, `q`=0,1,2,3,4 on edges 0–4 → `locked` rises after edge 4; `err=0` throughout.
- Pipeline fill: `q`=0,0,0,1,2,3,4 → no `err`; `locked` rises after the edge sampling 4.
- Wrap: while locked, `q`=14,15,0,1 → `wrap` high for exactly one cycle, after the edge sampling 0; `locked` stays high.
- Break and count: while locked, `q`=5,6,9,10 → one `err` pulse after the edge sampling 9; `locked` drops; `err_cnt`=1; relock after 4 further good steps.
- Saturation and clear: force 300 breaks → `err_cnt`=255. Assert `err_clr` together with a break → `err_cnt`=1.
- Async reset mid-lock: pull `reset_n` low between edges → `locked`, `err_cnt`, `match` go to 0 immediately; `match` with `cmp_val`=3 pulses once per 16-cycle wrap after relock.

Source files
------------

// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count-stream checker: FSM state encoding,
// run-length counter width and the wrapped-successor function.
package count_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int RUN_W = 8;

  // Value that should follow v on an n-bit counter, wrapping all-ones to zero.
  function automatic logic [31:0] wrap_succ(input logic [31:0] v, input int unsigned n);
    logic [31:0] mask;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return (v + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment on the
// same edge yields one, so an error coinciding with the clear is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors an N-bit count stream for +1 (mod 2^N) steps, locking after
// LOCK_LEN good steps. The error counter exists only with COUNT_CHECKER_ERR_CNT_EN.
module count_sequence_checker
  import count_chk_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N-1:0]     q,
  input  logic [N-1:0]     cmp_val,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic             match,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_LEN);

  chk_state_e       state_q;
  logic [N-1:0]     prev_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             locked_q, err_q, wrap_q, match_q;
  logic [N-1:0]     succ;
  logic             good;
  logic             err_evt;

  assign succ    = N'(wrap_succ(32'(prev_q), N));
  assign good    = (q == succ);
  assign run_d   = run_q + RUN_W'(1);
  assign err_evt = en && (state_q == ST_LOCKED) && !good;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      match_q <= (q == cmp_val);
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      if (!en) begin
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQ;
            prev_q  <= q;
            run_q   <= '0;
          end
          ST_ACQ: begin
            prev_q <= q;
            if (good) begin
              run_q <= run_d;
              if (run_d == LOCK_TGT) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              run_q <= '0;
            end
          end
          ST_LOCKED: begin
            prev_q <= q;
            if (good) begin
              wrap_q <= &prev_q;
            end else begin
              err_q    <= 1'b1;
              state_q  <= ST_ACQ;
              run_q    <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked = locked_q;
  assign err    = err_q;
  assign wrap   = wrap_q;
  assign match  = match_q;

`ifdef COUNT_CHECKER_ERR_CNT_EN
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc_i  (err_evt),
    .clr_i  (err_clr),
    .cnt_o  (err_cnt)
  );
`else
  logic unused_err;
  assign unused_err = err_clr ^ err_evt;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed self-checking bench for count_sequence_checker (N=4, LOCK_LEN=4, ERR_W=8).
module tb_count_sequence_checker;

  logic       clk, reset_n, en, err_clr;
  logic [3:0] q, cmp_val;
  logic       locked, err, wrap, match;
  logic [7:0] err_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] v;

`ifdef COUNT_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  count_sequence_checker #(.N(4), .LOCK_LEN(4), .ERR_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .q      (q),
    .cmp_val(cmp_val),
    .err_clr(err_clr),
    .locked (locked),
    .err    (err),
    .wrap   (wrap),
    .match  (match),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] val);
    q = val;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; en = 1'b0; err_clr = 1'b0; q = 4'd0; cmp_val = 4'd3;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({locked, err, wrap, match, err_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%b/%b/%0d expected all zero", locked, err, wrap, match, err_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({locked, err, wrap, match, err_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %b/%b/%b/%b/%0d expected all zero", locked, err, wrap, match, err_cnt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    logic [3:0] vals [5]   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic       exp_lk [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vals[i]);
      checks++;
      if (locked !== exp_lk[i]) begin
        errors++; $display("FAIL lock_acquire.locked step %0d: got %b expected %b", i, locked, exp_lk[i]);
      end
      checks++;
      if (err !== 1'b0) begin
        errors++; $display("FAIL lock_acquire.err step %0d: got %b expected 0", i, err);
      end
      checks++;
      if (match !== (vals[i] == 4'd3)) begin
        errors++; $display("FAIL lock_acquire.match step %0d: got %b expected %b", i, match, vals[i] == 4'd3);
      end
    end
  endtask

  task automatic test_pipeline_fill();
    logic [3:0] vals [7]   = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic       exp_lk [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vals[i]);
      checks++;
      if (locked !== exp_lk[i] || err !== 1'b0) begin
        errors++; $display("FAIL pipeline_fill step %0d: got locked=%b err=%b expected locked=%b err=0", i, locked, err, exp_lk[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] vals [4]   = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic       exp_wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 5; i < 14; i++) begin
      drive(4'(i));
      checks++;
      if (locked !== 1'b1 || wrap !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL wrap.run q=%0d: got locked=%b wrap=%b err=%b expected 1/0/0", i, locked, wrap, err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(vals[i]);
      checks++;
      if (wrap !== exp_wr[i] || locked !== 1'b1) begin
        errors++; $display("FAIL wrap q=%0d: got wrap=%b locked=%b expected wrap=%b locked=1", vals[i], wrap, locked, exp_wr[i]);
      end
    end
  endtask

  task automatic test_break();
    logic [3:0] vals [10]   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic       exp_lk [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_er [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(vals[i]);
      exp_cnt = (CNT_EN && i >= 5) ? 8'd1 : 8'd0;
      checks++;
      if (locked !== exp_lk[i] || err !== exp_er[i]) begin
        errors++; $display("FAIL break q=%0d: got locked=%b err=%b expected locked=%b err=%b", vals[i], locked, err, exp_lk[i], exp_er[i]);
      end
      checks++;
      if (err_cnt !== exp_cnt) begin
        errors++; $display("FAIL break.err_cnt q=%0d: got %0d expected %0d", vals[i], err_cnt, exp_cnt);
      end
      checks++;
      if (match !== (vals[i] == 4'd3)) begin
        errors++; $display("FAIL break.match q=%0d: got %b expected %b", vals[i], match, vals[i] == 4'd3);
      end
    end
    v = 4'd13;
  endtask

  task automatic relock();
    for (int k = 0; k < 4; k++) begin
      v = v + 4'd1;
      drive(v);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt;
    for (int i = 0; i < 300; i++) begin
      v = v + 4'd2;
      drive(v);
      checks++;
      if (err !== 1'b1 || locked !== 1'b0) begin
        errors++; $display("FAIL sat.break %0d: got err=%b locked=%b expected err=1 locked=0", i, err, locked);
      end
      relock();
    end
    exp_cnt = CNT_EN ? 8'd255 : 8'd0;
    checks++;
    if (err_cnt !== exp_cnt) begin
      errors++; $display("FAIL sat.err_cnt: got %0d expected %0d", err_cnt, exp_cnt);
    end
    err_clr = 1'b1;
    v = v + 4'd2;
    drive(v);
    err_clr = 1'b0;
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    checks++;
    if (err_cnt !== exp_cnt || err !== 1'b1) begin
      errors++; $display("FAIL sat.clr_with_err: got cnt=%0d err=%b expected cnt=%0d err=1", err_cnt, err, exp_cnt);
    end
    relock();
    err_clr = 1'b1;
    v = v + 4'd1;
    drive(v);
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL sat.clr_alone: got cnt=%0d locked=%b expected cnt=0 locked=1", err_cnt, locked);
    end
    v = v + 4'd2;
    drive(v);
    relock();
    checks++;
    if (err_cnt !== exp_cnt || locked !== 1'b1) begin
      errors++; $display("FAIL sat.recount: got cnt=%0d locked=%b expected cnt=%0d locked=1", err_cnt, locked, exp_cnt);
    end
  endtask

  task automatic test_disable();
    logic [7:0] exp_cnt;
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    en = 1'b0;
    v = v + 4'd5;
    drive(v);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== exp_cnt) begin
      errors++; $display("FAIL disable: got locked=%b err=%b cnt=%0d expected 0/0/%0d", locked, err, err_cnt, exp_cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = v + 4'd1;
      drive(v);
      checks++;
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL disable.relock step %0d: got %b expected %b", i, locked, i == 4);
      end
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    for (int k = 0; k < 16; k++) begin
      v = v + 4'd1;
      drive(v);
      if (v == 4'd3) break;
    end
    checks++;
    if (locked !== 1'b1 || match !== 1'b1) begin
      errors++; $display("FAIL async.pre: got locked=%b match=%b expected 1/1", locked, match);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({locked, err, wrap, match, err_cnt} !== 12'h000) begin
      errors++; $display("FAIL async.cleared: got %b/%b/%b/%b/%0d expected all zero", locked, err, wrap, match, err_cnt);
    end
    #2 reset_n = 1'b1;
    v = 4'd0;
    drive(v);
    relock();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL async.relock: got %b expected 1", locked);
    end
    for (int i = 0; i < 32; i++) begin
      v = v + 4'd1;
      drive(v);
      if (match === 1'b1) pulses++;
      checks++;
      if (match !== (v == 4'd3) || wrap !== (v == 4'd0) || locked !== 1'b1) begin
        errors++; $display("FAIL async.run q=%0d: got match=%b wrap=%b locked=%b expected %b/%b/1", v, match, wrap, locked, v == 4'd3, v == 4'd0);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL async.match_count: got %0d expected 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_pipeline_fill();
    test_wrap();
    test_break();
    test_saturation();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
